shared_vc_slot_allocator: RTL and testbench
===========================================

Name: shared_vc_slot_allocator

Overview:
- Per-router controller for the shared (dynamic) VC buffer pool that backs the per-port private VC buffers.
- Input ports request one shared flit slot per cycle when their private VC credits run out.
- Round-robin arbitration issues at most one registered grant per cycle; the block tracks global and per-port occupancy and reclaims slots on credit return.
- Drives the per-port memory_bank_grant and credit_for_shared style signals consumed by flit sinks and input controllers.

Parameters:
- num_ports, 5, number of requesting router ports.
- shared_slots, 16, total flits in the shared pool (>=1).
- max_per_port, 8, cap on shared slots one port may hold (1..shared_slots).
- cnt_width, clogb(shared_slots+1), derived localparam; width of all occupancy counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  num_ports  per-port request for one shared slot this cycle.
- credit_ret  input  num_ports  per-port release of one held shared slot this cycle.
- drain  input  1  stop granting and wait for the pool to empty.
- grant  output  num_ports  one-hot (or zero) registered grant.
- free_count  output  cnt_width  free shared slots.
- port_count  output  num_ports*cnt_width  flattened per-port held-slot counts, port 0 in the MSBs.
- drained  output  1  high in QUIESCENT state.
- error  output  1  sticky protocol error.
- total_grants  output  32  grant statistics counter (see Optional Feature).

Behaviour:
- Reset values:
  - grant=0, free_count=shared_slots, all port_count=0, drained=0, error=0, total_grants=0.
  - Round-robin pointer=0; state=RUN.
- Eligibility: eligible[p] = req[p] & (port_count[p] < max_per_port) & (free_count > 0) & (state==RUN).
- Arbitration:
  - Round-robin starting at pointer; the winner w is registered into grant in the cycle after req is sampled (latency 1).
  - The pointer advances to w+1 mod num_ports only when a grant issues. There is no grant when no port is eligible.
- Accounting, same edge as grant is registered:
  - free_next = free - g + popcount(valid_ret).
  - port_count[p]_next = port_count[p] + (w==p) - valid_ret[p].
  - Arithmetic is in cnt_width+1 bits; the result never exceeds shared_slots.
- Credit returns:
  - valid_ret[p] = credit_ret[p] & (port_count[p] > 0).
  - credit_ret[p] with port_count[p]==0 is ignored and sets error.
- Simultaneous grant to and return from the same port: net count unchanged.
- A grant when free==1 coinciding with returns is permitted. Returns in the same cycle cannot enable an extra grant, because eligibility uses the current count.
- FSM:
  - RUN -> DRAIN when drain=1.
  - DRAIN -> QUIESCENT when free_count==shared_slots (same cycle if already full).
  - DRAIN or QUIESCENT -> RUN when drain=0.
  - Returns are still accepted in DRAIN and QUIESCENT.
- Invariant: sum(port_count) + free_count == shared_slots. Violation sets error (simulation assertion also required).
- Reset mid-operation: all state returns to reset values immediately; outstanding slots are forgotten.

Optional Feature:
- SHARED_ALLOC_STATS_EN defined: total_grants is a 32-bit counter incremented per issued grant, wrapping 0xFFFFFFFF->0 and cleared on reset.
- Undefined: total_grants tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package/include (rtr_constants.v style) holds:
  - FSM state encodings: RUN=2'd0, DRAIN=2'd1, QUIESCENT=2'd2.
  - The clogb-based width helper.
- Natural sub-module: shared_slot_rr_arbiter. It is a combinational round-robin pick plus the pointer register with an update input. It is reusable by other allocators.

Test Plan:
- Reset, then req=5'b10100 held → grants alternate port0, port2, port0, ... (one per cycle, latency 1); free_count decrements 16→15→14...
- Single port 0 requests continuously with max_per_port=8 → exactly 8 grants, then grant stays 0; port_count[0]=8, free_count=8.
- Fill pool (16 grants across ports), then credit_ret=5'b11000 → free_count 0→2; next req is granted the following cycle.
- Same cycle: grant to port 1 and credit_ret[1] → port_count[1] unchanged, free_count unchanged, error=0.
- credit_ret[3] while port_count[3]=0 → error=1 and stays 1; all counts unchanged.
- drain=1 with 3 slots held → no grants, drained=0. Return the 3 credits → drained=1. drain=0 → RUN and grants resume. With SHARED_ALLOC_STATS_EN defined, total_grants equals the number of grants issued.

Source files
------------

// File: rtl/shared_vc_slot_allocator_pkg.sv
// Shared definitions for the shared VC slot allocator: FSM encodings and the
// ceil-log2 width helper used to size counters and indices.
package shared_vc_slot_allocator_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_QUIESCENT = 2'd2
    } alloc_state_e;

    function automatic int clogb(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/shared_slot_rr_arbiter.sv
// Round-robin picker: combinational search from the pointer, plus the pointer
// register that moves past the winner whenever update_i is asserted.
module shared_slot_rr_arbiter
    import shared_vc_slot_allocator_pkg::*;
#(
    parameter  int num_ports = 5,
    localparam int idx_width = (num_ports > 1) ? clogb(num_ports) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_ports-1:0] req_i,
    input  logic                 update_i,
    output logic                 valid_o,
    output logic [idx_width-1:0] winner_o
);

    logic [idx_width-1:0] ptr_q;
    logic [idx_width-1:0] ptr_d;
    logic [idx_width-1:0] idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = 0; i < num_ports; i++) begin
            idx = idx_width'((int'(ptr_q) + i) % num_ports);
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = (winner_o == idx_width'(num_ports - 1)) ? '0 : winner_o + idx_width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_vc_slot_allocator.sv
// Shared VC buffer pool controller: one registered round-robin grant per cycle,
// global/per-port occupancy tracking, drain FSM. SHARED_ALLOC_STATS_EN enables total_grants_o.
module shared_vc_slot_allocator
    import shared_vc_slot_allocator_pkg::*;
#(
    parameter  int num_ports    = 5,
    parameter  int shared_slots = 16,
    parameter  int max_per_port = 8,
    localparam int cnt_width    = clogb(shared_slots + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports-1:0]           req_i,
    input  logic [num_ports-1:0]           credit_ret_i,
    input  logic                           drain_i,
    output logic [num_ports-1:0]           grant_o,
    output logic [cnt_width-1:0]           free_count_o,
    output logic [num_ports*cnt_width-1:0] port_count_o,
    output logic                           drained_o,
    output logic                           error_o,
    output logic [31:0]                    total_grants_o,
    output logic [1:0]                     state_o
);

    localparam int idx_width = (num_ports > 1) ? clogb(num_ports) : 1;

    // Internal vectors are indexed by port number; the port-level buses carry port 0 in the MSB.
    logic [num_ports-1:0] req_port, ret_port, grant_q, grant_d;
    logic [num_ports-1:0] eligible, valid_ret;
    logic [cnt_width-1:0] port_cnt_q [num_ports];
    logic [cnt_width-1:0] port_cnt_d [num_ports];
    logic [cnt_width-1:0] free_q, free_d;
    logic [cnt_width:0]   ret_count, free_wide;
    logic                 error_q, error_d, bad_ret, inv_ok;
    logic                 arb_valid;
    logic [idx_width-1:0] arb_winner;
    int                   occupied;
    alloc_state_e         state_q, state_d;

    for (genvar p = 0; p < num_ports; p++) begin : g_port_map
        assign req_port[p] = req_i[num_ports-1-p];
        assign ret_port[p] = credit_ret_i[num_ports-1-p];
        assign grant_o[num_ports-1-p] = grant_q[p];
        assign port_count_o[(num_ports-1-p)*cnt_width +: cnt_width] = port_cnt_q[p];
    end

    shared_slot_rr_arbiter #(.num_ports(num_ports)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (eligible),
        .update_i (arb_valid),
        .valid_o  (arb_valid),
        .winner_o (arb_winner)
    );

    always_comb begin
        bad_ret   = 1'b0;
        ret_count = '0;
        occupied  = 0;
        for (int p = 0; p < num_ports; p++) begin
            valid_ret[p] = ret_port[p] && (port_cnt_q[p] != '0);
            bad_ret      = bad_ret | (ret_port[p] && (port_cnt_q[p] == '0));
            eligible[p]  = req_port[p] && (port_cnt_q[p] < cnt_width'(max_per_port))
                           && (free_q != '0) && (state_q == ST_RUN);
            ret_count    = ret_count + (cnt_width+1)'(valid_ret[p]);
            occupied     = occupied + int'(port_cnt_q[p]);
        end
        grant_d = '0;
        if (arb_valid) begin
            grant_d[arb_winner] = 1'b1;
        end
        free_wide = {1'b0, free_q} - (cnt_width+1)'(arb_valid) + ret_count;
        free_d    = free_wide[cnt_width-1:0];
        for (int p = 0; p < num_ports; p++) begin
            port_cnt_d[p] = port_cnt_q[p] + cnt_width'(grant_d[p]) - cnt_width'(valid_ret[p]);
        end
        inv_ok  = (occupied + int'(free_q)) == shared_slots;
        error_d = error_q | bad_ret | !inv_ok | (free_wide > (cnt_width+1)'(shared_slots));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            free_q  <= cnt_width'(shared_slots);
            error_q <= 1'b0;
            for (int p = 0; p < num_ports; p++) begin
                port_cnt_q[p] <= '0;
            end
        end else begin
            grant_q <= grant_d;
            free_q  <= free_d;
            error_q <= error_d;
            for (int p = 0; p < num_ports; p++) begin
                port_cnt_q[p] <= port_cnt_d[p];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (drain_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_i) state_d = ST_RUN;
                else if (free_q == cnt_width'(shared_slots)) state_d = ST_QUIESCENT;
            end
            ST_QUIESCENT: if (!drain_i) state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
    end

    always_comb begin
        drained_o = (state_q == ST_QUIESCENT);
        state_o   = state_q;
    end

    assign free_count_o = free_q;
    assign error_o      = error_q;

`ifdef SHARED_ALLOC_STATS_EN
    logic [31:0] total_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= '0;
        end else if (arb_valid) begin
            total_q <= total_q + 32'd1;
        end
    end

    assign total_grants_o = total_q;
`else
    assign total_grants_o = '0;
`endif

    occupancy_invariant: assert property (@(posedge clk) disable iff (reset) inv_ok);

endmodule

// File: tb/tb_shared_vc_slot_allocator.sv
// Directed bench for shared_vc_slot_allocator (5 ports, 16 slots, cap 8);
// port p maps to bit 4-p of every port vector.
module tb_shared_vc_slot_allocator;

    logic        clk;
    logic        reset;
    logic [4:0]  req_i;
    logic [4:0]  credit_ret_i;
    logic        drain_i;
    logic [4:0]  grant_o;
    logic [4:0]  free_count_o;
    logic [24:0] port_count_o;
    logic        drained_o;
    logic        error_o;
    logic [31:0] total_grants_o;
    logic [1:0]  state_o;

    int vectors     = 0;
    int miscompares = 0;
    int exp_total   = 0;

`ifdef SHARED_ALLOC_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    shared_vc_slot_allocator dut (
        .clk            (clk),
        .reset          (reset),
        .req_i          (req_i),
        .credit_ret_i   (credit_ret_i),
        .drain_i        (drain_i),
        .grant_o        (grant_o),
        .free_count_o   (free_count_o),
        .port_count_o   (port_count_o),
        .drained_o      (drained_o),
        .error_o        (error_o),
        .total_grants_o (total_grants_o),
        .state_o        (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] pv(input int p);
        logic [4:0] v;
        v = '0;
        v[4-p] = 1'b1;
        return v;
    endfunction

    function automatic logic [4:0] pc(input int p);
        return port_count_o[(4-p)*5 +: 5];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_total(input string tag);
        chk(tag, total_grants_o, stats_en ? 32'(exp_total) : 32'd0);
    endtask

    initial begin
        logic [4:0] exp_g;
        int         exp_f;

        reset = 1'b1; req_i = '0; credit_ret_i = '0; drain_i = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant_o, 0);
        chk("rst_free", free_count_o, 16);
        chk("rst_pcount", port_count_o, 0);
        chk("rst_drained", drained_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_state", state_o, 0);
        chk_total("rst_total");
        reset = 1'b0;

        // Ports 0 and 2 requesting: alternate grants, one per cycle.
        req_i = 5'b10100;
        tick(); chk("rr1_grant", grant_o, pv(0)); chk("rr1_free", free_count_o, 15);
        tick(); chk("rr2_grant", grant_o, pv(2)); chk("rr2_free", free_count_o, 14);
        tick(); chk("rr3_grant", grant_o, pv(0)); chk("rr3_free", free_count_o, 13);
        tick(); chk("rr4_grant", grant_o, pv(2)); chk("rr4_free", free_count_o, 12);
        exp_total += 4;
        req_i = '0;
        tick();
        chk("rr_idle_grant", grant_o, 0);
        chk("rr_pc0", pc(0), 2);
        chk("rr_pc2", pc(2), 2);
        chk_total("rr_total");

        // Asynchronous reset mid-operation.
        reset = 1'b1;
        #2;
        chk("midrst_free", free_count_o, 16);
        chk("midrst_pcount", port_count_o, 0);
        exp_total = 0;
        chk_total("midrst_total");
        tick();
        reset = 1'b0;

        // Port 0 alone: capped at 8 held slots.
        req_i = pv(0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_g = (k <= 8) ? pv(0) : 5'd0;
            exp_f = (k <= 8) ? 16 - k : 8;
            chk($sformatf("cap%0d_grant", k), grant_o, exp_g);
            chk($sformatf("cap%0d_free", k), free_count_o, exp_f);
        end
        exp_total += 8;
        chk("cap_pc0", pc(0), 8);
        chk_total("cap_total");

        // Fill the pool with ports 1 and 2, then grants stop at free==0.
        req_i = pv(1) | pv(2);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_g = (k % 2 == 1) ? pv(1) : pv(2);
            chk($sformatf("fill%0d_grant", k), grant_o, exp_g);
            chk($sformatf("fill%0d_free", k), free_count_o, 8 - k);
        end
        exp_total += 8;
        tick();
        chk("full_grant", grant_o, 0);
        chk("full_free", free_count_o, 0);
        req_i = '0;
        credit_ret_i = 5'b11000;
        tick();
        chk("ret2_free", free_count_o, 2);
        chk("ret2_pc0", pc(0), 7);
        chk("ret2_pc1", pc(1), 3);
        chk("ret2_error", error_o, 0);
        credit_ret_i = '0;
        req_i = pv(3);
        tick();
        chk("after_ret_grant", grant_o, pv(3));
        chk("after_ret_free", free_count_o, 1);
        exp_total += 1;

        // Grant and return on port 1 in the same cycle, with free==1.
        req_i = pv(1);
        credit_ret_i = pv(1);
        tick();
        chk("same_grant", grant_o, pv(1));
        chk("same_pc1", pc(1), 3);
        chk("same_free", free_count_o, 1);
        chk("same_error", error_o, 0);
        exp_total += 1;
        credit_ret_i = '0;
        req_i = pv(2);
        tick();
        chk("last_grant", grant_o, pv(2));
        chk("last_free", free_count_o, 0);
        exp_total += 1;
        // A return in the same cycle cannot enable a grant while free==0.
        credit_ret_i = pv(0);
        tick();
        chk("noextra_grant", grant_o, 0);
        chk("noextra_free", free_count_o, 1);
        chk("noextra_pc0", pc(0), 6);
        chk("noextra_pc2", pc(2), 5);
        chk_total("mid_total");

        // Spurious return on port 3 sets the sticky error.
        req_i = '0;
        credit_ret_i = pv(3);
        tick();
        chk("ret3_pc3", pc(3), 0);
        chk("ret3_free", free_count_o, 2);
        chk("ret3_error", error_o, 0);
        tick();
        chk("bad_error", error_o, 1);
        chk("bad_pc3", pc(3), 0);
        chk("bad_free", free_count_o, 2);
        credit_ret_i = '0;
        tick();
        chk("sticky_error", error_o, 1);
        chk("sticky_pc0", pc(0), 6);

        // Drain sequence with 3 slots held.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_total = 0;
        chk("rst2_error", error_o, 0);
        req_i = pv(0) | pv(1) | pv(4);
        tick(); chk("dr_g1", grant_o, pv(0));
        tick(); chk("dr_g2", grant_o, pv(1));
        tick(); chk("dr_g3", grant_o, pv(4)); chk("dr_free", free_count_o, 13);
        exp_total += 3;
        req_i = '0;
        drain_i = 1'b1;
        tick();
        chk("drain_state", state_o, 1);
        chk("drain_drained", drained_o, 0);
        chk("drain_grant", grant_o, 0);
        req_i = pv(2);
        tick();
        chk("drain_nogrant", grant_o, 0);
        chk("drain_busy", drained_o, 0);
        credit_ret_i = pv(0) | pv(1) | pv(4);
        tick();
        chk("drain_free", free_count_o, 16);
        chk("drain_pcount", port_count_o, 0);
        chk("drain_pending", drained_o, 0);
        chk("drain_nogrant2", grant_o, 0);
        credit_ret_i = '0;
        tick();
        chk("quiesce_state", state_o, 2);
        chk("quiesce_drained", drained_o, 1);
        chk("quiesce_grant", grant_o, 0);
        drain_i = 1'b0;
        tick();
        chk("resume_state", state_o, 0);
        chk("resume_drained", drained_o, 0);
        chk("resume_grant0", grant_o, 0);
        tick();
        chk("resume_grant", grant_o, pv(2));
        chk("resume_free", free_count_o, 15);
        exp_total += 1;
        chk("resume_error", error_o, 0);
        chk_total("final_total");
        req_i = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
